// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the reorder-buffer retire block.
package rob_retire_pkg;
  localparam int ROBID_W       = 8;
  localparam int ROB_DEPTH_DFLT = 128;

  typedef struct packed {
    logic [5:0]  rd;
    logic [31:0] result;
    logic        wrap;
    logic        done;
    logic        error;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_entry_ram.sv
// Payload storage for ROB entries: allocation write, writeback write, head read.
module rob_entry_ram #(
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             i_alloc_we,
  input  logic [IDX_W-1:0] i_alloc_idx,
  input  logic [5:0]       i_alloc_rd,
  input  logic             i_alloc_wrap,
  input  logic             i_wb_we,
  input  logic [IDX_W-1:0] i_wb_idx,
  input  logic [31:0]      i_wb_result,
  input  logic             i_wb_error,
  input  logic [IDX_W-1:0] i_head_idx,
  output logic [5:0]       o_head_rd,
  output logic [31:0]      o_head_result,
  output logic             o_head_wrap,
  output logic             o_head_error
);
  logic [5:0]  r_rd     [DEPTH];
  logic [31:0] r_result [DEPTH];
  logic        r_wrap   [DEPTH];
  logic        r_error  [DEPTH];

  // Both ports never target the same entry: writeback only lands on allocated entries.
  always_ff @(posedge clk) begin
    if (i_alloc_we) begin
      r_rd[i_alloc_idx]    <= i_alloc_rd;
      r_wrap[i_alloc_idx]  <= i_alloc_wrap;
      r_error[i_alloc_idx] <= 1'b0;
    end
    if (i_wb_we) begin
      r_result[i_wb_idx] <= i_wb_result;
      r_error[i_wb_idx]  <= i_wb_error;
    end
  end

  assign o_head_rd     = r_rd[i_head_idx];
  assign o_head_result = r_result[i_head_idx];
  assign o_head_wrap   = r_wrap[i_head_idx];
  assign o_head_error  = r_error[i_head_idx];
endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: allocate at tail, complete out of order, retire/flush at head.
// Optional ROB_PERF_EN adds retire and flush counters.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rename_rob_valid,
  input  logic [5:0]         rename_rob_rd,
  output logic               rob_rename_ready,
  output logic [ROBID_W-1:0] rob_rename_robid,
  input  logic               wb_valid,
  input  logic               wb_error,
  input  logic [ROBID_W-1:0] wb_robid,
  input  logic [31:0]        wb_result,
  output logic               rob_ret_valid,
  output logic [5:0]         rob_ret_rd,
  output logic [31:0]        rob_ret_result,
`ifdef ROB_PERF_EN
  output logic [31:0]        rob_perf_retired,
  output logic [31:0]        rob_perf_flushes,
`endif
  output logic               rob_flush
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROB_DEPTH - 1);

  logic [IDX_W-1:0]     r_head, r_tail;
  logic                 r_tail_wrap;
  logic [CNT_W-1:0]     r_count;
  logic [ROB_DEPTH-1:0] r_alloc, r_done;

  rob_entry_t       w_head;
  logic [5:0]       w_head_rd;
  logic [31:0]      w_head_result;
  logic             w_head_wrap, w_head_error;
  logic [IDX_W-1:0] w_wb_idx;
  logic             w_wb_in_range, w_wb_wrap_exp, w_wb_hit;
  logic             w_ret, w_err, w_alloc;

  assign w_head = '{rd: w_head_rd, result: w_head_result, wrap: w_head_wrap,
                    done: r_done[r_head], error: w_head_error};

  assign w_ret = r_alloc[r_head] & w_head.done & ~w_head.error;
  assign w_err = r_alloc[r_head] & w_head.done &  w_head.error;

  assign rob_rename_ready = (r_count < FULL_CNT) && !w_err;
  assign rob_rename_robid = {r_tail_wrap, 7'(r_tail)};
  assign w_alloc          = rename_rob_valid && rob_rename_ready && !rst;

  assign w_wb_idx = wb_robid[IDX_W-1:0];
  generate
    if (IDX_W < 7) begin : g_hi_chk
      assign w_wb_in_range = (wb_robid[6:IDX_W] == '0);
    end else begin : g_no_hi
      assign w_wb_in_range = 1'b1;
    end
  endgenerate

  // Live entries run head..tail, so an index at/after head shares the head's lap.
  assign w_wb_wrap_exp = (w_wb_idx >= r_head) ? w_head.wrap : ~w_head.wrap;
  assign w_wb_hit = wb_valid && !rob_flush && !rst && w_wb_in_range &&
                    r_alloc[w_wb_idx] && (wb_robid[7] == w_wb_wrap_exp);

  rob_entry_ram #(.DEPTH(ROB_DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk          (clk),
    .i_alloc_we   (w_alloc && !w_err),
    .i_alloc_idx  (r_tail),
    .i_alloc_rd   (rename_rob_rd),
    .i_alloc_wrap (r_tail_wrap),
    .i_wb_we      (w_wb_hit && !w_err),
    .i_wb_idx     (w_wb_idx),
    .i_wb_result  (wb_result),
    .i_wb_error   (wb_error),
    .i_head_idx   (r_head),
    .o_head_rd    (w_head_rd),
    .o_head_result(w_head_result),
    .o_head_wrap  (w_head_wrap),
    .o_head_error (w_head_error)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_tail_wrap    <= 1'b0;
      r_count        <= '0;
      r_alloc        <= '0;
      r_done         <= '0;
      rob_ret_valid  <= 1'b0;
      rob_ret_rd     <= '0;
      rob_ret_result <= '0;
      rob_flush      <= 1'b0;
    end else if (w_err) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_tail_wrap   <= 1'b0;
      r_count       <= '0;
      r_alloc       <= '0;
      r_done        <= '0;
      rob_ret_valid <= 1'b0;
      rob_flush     <= 1'b1;
    end else begin
      rob_flush     <= 1'b0;
      rob_ret_valid <= w_ret;
      if (w_ret) begin
        rob_ret_rd       <= w_head.rd;
        rob_ret_result   <= w_head.result;
        r_alloc[r_head]  <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      if (w_wb_hit) r_done[w_wb_idx] <= 1'b1;
      if (w_alloc) begin
        r_alloc[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
        if (r_tail == LAST_IDX) r_tail_wrap <= ~r_tail_wrap;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_ret);
    end
  end

`ifdef ROB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_perf_retired <= '0;
      rob_perf_flushes <= '0;
    end else begin
      if (w_ret) rob_perf_retired <= rob_perf_retired + 32'd1;
      if (w_err) rob_perf_flushes <= rob_perf_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rob_retire.sv
// Randomized bench for rob_retire against a queue-based ROB model.
module tb_rob_retire;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        rename_rob_valid;
  logic [5:0]  rename_rob_rd;
  logic        rob_rename_ready;
  logic [7:0]  rob_rename_robid;
  logic        wb_valid, wb_error;
  logic [7:0]  wb_robid;
  logic [31:0] wb_result;
  logic        rob_ret_valid;
  logic [5:0]  rob_ret_rd;
  logic [31:0] rob_ret_result;
  logic        rob_flush;
`ifdef ROB_PERF_EN
  logic [31:0] rob_perf_retired, rob_perf_flushes;
`endif

  always #5 clk = ~clk;

  rob_retire #(.ROB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rename_rob_valid(rename_rob_valid), .rename_rob_rd(rename_rob_rd),
    .rob_rename_ready(rob_rename_ready), .rob_rename_robid(rob_rename_robid),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_result(wb_result),
    .rob_ret_valid(rob_ret_valid), .rob_ret_rd(rob_ret_rd), .rob_ret_result(rob_ret_result),
`ifdef ROB_PERF_EN
    .rob_perf_retired(rob_perf_retired), .rob_perf_flushes(rob_perf_flushes),
`endif
    .rob_flush(rob_flush)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    int          seq;
    logic [5:0]  rd;
    bit          done;
    bit          err;
    logic [31:0] res;
  } ment_t;

  ment_t       q[$];
  int          m_seq;
  bit          m_rv, m_flush;
  logic [5:0]  m_rd;
  logic [31:0] m_res;
  int          m_nret, m_nflush;

  function automatic logic [7:0] id_of(input int s);
    logic [7:0] r;
    r[7]   = ((s / DEPTH) % 2) != 0;
    r[6:0] = 7'(s % DEPTH);
    return r;
  endfunction

  task automatic step(input bit av, input logic [5:0] ard, input bit wv, input bit we,
                      input logic [7:0] wid, input logic [31:0] wres);
    bit err_now, ret_now, m_ready;
    logic [5:0]  front_rd;
    logic [31:0] front_res;
    rename_rob_valid = av; rename_rob_rd = ard;
    wb_valid = wv; wb_error = we; wb_robid = wid; wb_result = wres;
    err_now = q.size() > 0 && q[0].done && q[0].err;
    ret_now = q.size() > 0 && q[0].done && !q[0].err;
    m_ready = q.size() < DEPTH && !err_now;
    chk("ready", 32'(rob_rename_ready), 32'(m_ready));
    chk("robid", 32'(rob_rename_robid), 32'(id_of(m_seq)));
    if (err_now) begin
      q.delete();
      m_seq = 0; m_rv = 1'b0; m_flush = 1'b1; m_nflush++;
    end else begin
      front_rd  = (q.size() > 0) ? q[0].rd  : 6'h0;
      front_res = (q.size() > 0) ? q[0].res : 32'h0;
      if (wv && !m_flush)
        foreach (q[i]) if (id_of(q[i].seq) == wid) begin
          q[i].done = 1'b1; q[i].err = we; q[i].res = wres;
        end
      m_rv = ret_now;
      if (ret_now) begin
        m_rd = front_rd; m_res = front_res;
        void'(q.pop_front());
        m_nret++;
      end
      if (av && m_ready) begin
        q.push_back('{m_seq, ard, 1'b0, 1'b0, 32'h0});
        m_seq++;
      end
      m_flush = 1'b0;
    end
    @(posedge clk); #1;
    chk("ret_valid",  32'(rob_ret_valid), 32'(m_rv));
    chk("ret_rd",     32'(rob_ret_rd),    32'(m_rd));
    chk("ret_result", rob_ret_result,     m_res);
    chk("flush",      32'(rob_flush),     32'(m_flush));
  endtask

  task automatic idle();
    step(1'b0, 6'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic alloc(input logic [5:0] rd);
    step(1'b1, rd, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic wb(input logic [7:0] id, input bit e, input logic [31:0] res);
    step(1'b0, 6'h0, 1'b1, e, id, res);
  endtask

  // Drives live-looking requests during reset to show reset wins.
  task automatic do_reset();
    rst = 1'b1;
    rename_rob_valid = 1'b1; rename_rob_rd = 6'h3f;
    wb_valid = 1'b1; wb_error = 1'b1; wb_robid = 8'h00; wb_result = 32'hffff_ffff;
    @(posedge clk); #1;
    rst = 1'b0;
    rename_rob_valid = 1'b0; wb_valid = 1'b0; wb_error = 1'b0;
    q.delete();
    m_seq = 0; m_rv = 1'b0; m_flush = 1'b0; m_rd = '0; m_res = '0;
    m_nret = 0; m_nflush = 0;
    chk("rst_ret_valid", 32'(rob_ret_valid), 32'd0);
    chk("rst_flush",     32'(rob_flush),     32'd0);
    chk("rst_ret_rd",    32'(rob_ret_rd),    32'd0);
    chk("rst_ret_res",   rob_ret_result,     32'd0);
    chk("rst_ready",     32'(rob_rename_ready), 32'd1);
    chk("rst_robid",     32'(rob_rename_robid), 32'd0);
  endtask

  initial begin
    int k;
    logic [7:0] wid;

    // single alloc/wb/retire
    do_reset();
    alloc(6'h25);
    wb(8'h00, 1'b0, 32'hDEADBEEF);
    idle();
    chk("t1_rv", 32'(rob_ret_valid), 32'd1);
    chk("t1_rd", 32'(rob_ret_rd), 32'h25);
    chk("t1_res", rob_ret_result, 32'hDEADBEEF);

    // out-of-order completion, in-order retire
    do_reset();
    alloc(6'h01); alloc(6'h02);
    wb(8'h01, 1'b0, 32'h111); wb(8'h00, 1'b0, 32'h222);
    idle();
    chk("ooo_rd0", 32'(rob_ret_rd), 32'h01);
    chk("ooo_res0", rob_ret_result, 32'h222);
    idle();
    chk("ooo_rd1", 32'(rob_ret_rd), 32'h02);
    chk("ooo_res1", rob_ret_result, 32'h111);

    // fill, blocked alloc, retire reopens, wrap id
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(6'(i));
    chk("full_ready", 32'(rob_rename_ready), 32'd0);
    alloc(6'h2a);
    wb(8'h00, 1'b0, 32'h5);
    chk("full_ready_wb", 32'(rob_rename_ready), 32'd0);
    idle();
    chk("full_ret", 32'(rob_ret_valid), 32'd1);
    chk("reopen_ready", 32'(rob_rename_ready), 32'd1);
    chk("wrap_robid", 32'(rob_rename_robid), 32'h80);
    alloc(6'h11);

    // error at head flushes
    do_reset();
    for (int i = 0; i < 4; i++) alloc(6'(i + 8));
    wb(8'h00, 1'b1, 32'hBAD);
    idle();
    chk("flush_pulse", 32'(rob_flush), 32'd1);
    chk("flush_noret", 32'(rob_ret_valid), 32'd0);
    chk("flush_robid", 32'(rob_rename_robid), 32'h00);
    wb(8'h02, 1'b0, 32'h77);
    chk("flush_once", 32'(rob_flush), 32'd0);
    idle(); idle();
    chk("stale_wb_noret", 32'(rob_ret_valid), 32'd0);

    // wrong-lap writebacks ignored
    do_reset();
    for (int i = 0; i < 6; i++) alloc(6'(i));
    wb(8'h85, 1'b0, 32'h55); wb(8'h80, 1'b0, 32'h66);
    idle(); idle();
    chk("lap_noret", 32'(rob_ret_valid), 32'd0);
    wb(8'h00, 1'b0, 32'h99);
    idle();
    chk("lap_ret_ok", 32'(rob_ret_valid), 32'd1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (q.size() > 0 && $urandom_range(7) != 0) begin
        k = $urandom_range(q.size() - 1);
        wid = id_of(q[k].seq);
      end else begin
        wid = 8'($urandom);
      end
      step(($urandom_range(3) != 0), 6'($urandom), ($urandom_range(9) < 6),
           ($urandom_range(49) == 0), wid, $urandom);
    end
    repeat (4) idle();

`ifdef ROB_PERF_EN
    chk("perf_retired", rob_perf_retired, 32'(m_nret));
    chk("perf_flushes", rob_perf_flushes, 32'(m_nflush));
    do_reset();
    chk("perf_ret_rst", rob_perf_retired, 32'd0);
    chk("perf_fl_rst",  rob_perf_flushes, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
